// File: rtl/inst_fetch_pkg.sv
// Shared constants and FSM encoding for the instruction fetch stage.
package inst_fetch_pkg;

   localparam logic [31:0] IF_RESET_PC = 32'hBFC0_0000;
   localparam logic [31:0] IF_NOP      = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DRAIN = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/fetch_skid_reg.sv
// One-entry {addr, inst} holding register for a word fetched while ID is stalled.
module fetch_skid_reg #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic              i_clear,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [INST_W-1:0] i_inst,
   output logic [ADDR_W-1:0] o_addr,
   output logic [INST_W-1:0] o_inst,
   output logic              o_valid
);

   logic              r_valid;
   logic [ADDR_W-1:0] r_addr;
   logic [INST_W-1:0] r_inst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          r_valid <= 1'b0;
      else if (i_clear) r_valid <= 1'b0;
      else if (i_load)  r_valid <= 1'b1;
   end

   // Payload carries no reset; r_valid alone qualifies it.
   always_ff @(posedge clk) begin
      if (i_load) begin
         r_addr <= i_addr;
         r_inst <= i_inst;
      end
   end

   assign o_addr  = r_addr;
   assign o_inst  = r_inst;
   assign o_valid = r_valid;

endmodule

// File: rtl/inst_fetch.sv
// MIPS32 IF stage: single-outstanding ROM fetch, delay-slot branch redirect, stall skid and flush drain.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                INST_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IF_RESET_PC)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_in,
   input  logic              flush,
   input  logic [ADDR_W-1:0] flush_pc,
   input  logic              branch_flag,
   input  logic [ADDR_W-1:0] branch_addr,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic              rom_ready,
   input  logic [INST_W-1:0] rom_rdata,
   output logic [ADDR_W-1:0] id_addr,
   output logic [INST_W-1:0] id_inst,
   output logic              id_valid
);

   fetch_state_t      r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_pc, w_pc_nxt;
   logic              r_redir_pend, w_redir_pend_nxt;
   logic [ADDR_W-1:0] r_redir_tgt, w_redir_tgt_nxt;
   logic [ADDR_W-1:0] r_flush_pc, w_flush_pc_nxt;
   logic [ADDR_W-1:0] r_id_addr, w_id_addr_nxt;
   logic [INST_W-1:0] r_id_inst, w_id_inst_nxt;
   logic              r_id_valid, w_id_valid_nxt;

   logic              w_skid_load, w_skid_clear, w_skid_valid;
   logic [ADDR_W-1:0] w_skid_addr;
   logic [INST_W-1:0] w_skid_inst;

   logic              w_take;
   logic [ADDR_W-1:0] w_adv_addr, w_adv_pc;
   logic [INST_W-1:0] w_adv_inst;

   fetch_skid_reg #(.ADDR_W(ADDR_W), .INST_W(INST_W)) u_skid (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_skid_load),
      .i_clear (w_skid_clear),
      .i_addr  (r_pc),
      .i_inst  (rom_rdata),
      .o_addr  (w_skid_addr),
      .o_inst  (w_skid_inst),
      .o_valid (w_skid_valid)
   );

   // A taken branch always belongs to the instruction leaving the output regs,
   // so the entering word is its delay slot and the redirect applies to the pc after it.
   assign w_take     = branch_flag & r_id_valid;
   assign w_adv_addr = w_skid_valid ? w_skid_addr : r_pc;
   assign w_adv_inst = w_skid_valid ? w_skid_inst : rom_rdata;
   assign w_adv_pc   = w_take       ? branch_addr :
                       r_redir_pend ? r_redir_tgt : w_adv_addr + ADDR_W'(4);

   always_comb begin
      w_state_nxt      = r_state;
      w_pc_nxt         = r_pc;
      w_redir_pend_nxt = r_redir_pend;
      w_redir_tgt_nxt  = r_redir_tgt;
      w_flush_pc_nxt   = r_flush_pc;
      w_id_addr_nxt    = r_id_addr;
      w_id_inst_nxt    = r_id_inst;
      w_id_valid_nxt   = r_id_valid;
      w_skid_load      = 1'b0;
      w_skid_clear     = 1'b0;
      if (flush) begin
         w_id_inst_nxt    = INST_W'(IF_NOP);
         w_id_valid_nxt   = 1'b0;
         w_redir_pend_nxt = 1'b0;
         if ((r_state == ST_REQ || r_state == ST_DRAIN) && !rom_ready) begin
            w_state_nxt    = ST_DRAIN;
            w_flush_pc_nxt = flush_pc;
         end else begin
            w_state_nxt  = ST_REQ;
            w_pc_nxt     = flush_pc;
            w_skid_clear = 1'b1;
         end
      end else begin
         case (r_state)
            ST_IDLE: w_state_nxt = ST_REQ;
            ST_REQ: begin
               if (!stall_in && rom_ready) begin
                  w_id_addr_nxt    = w_adv_addr;
                  w_id_inst_nxt    = w_adv_inst;
                  w_id_valid_nxt   = 1'b1;
                  w_pc_nxt         = w_adv_pc;
                  w_redir_pend_nxt = 1'b0;
               end else if (!stall_in) begin
                  w_id_inst_nxt  = INST_W'(IF_NOP);
                  w_id_valid_nxt = 1'b0;
                  if (w_take) begin
                     w_redir_pend_nxt = 1'b1;
                     w_redir_tgt_nxt  = branch_addr;
                  end
               end else if (rom_ready) begin
                  w_skid_load = 1'b1;
                  w_state_nxt = ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (!stall_in) begin
                  w_id_addr_nxt    = w_adv_addr;
                  w_id_inst_nxt    = w_adv_inst;
                  w_id_valid_nxt   = 1'b1;
                  w_pc_nxt         = w_adv_pc;
                  w_redir_pend_nxt = 1'b0;
                  w_skid_clear     = 1'b1;
                  w_state_nxt      = ST_REQ;
               end
            end
            ST_DRAIN: begin
               if (rom_ready) begin
                  w_pc_nxt    = r_flush_pc;
                  w_state_nxt = ST_REQ;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_pc         <= RESET_PC;
         r_redir_pend <= 1'b0;
         r_id_addr    <= '0;
         r_id_inst    <= '0;
         r_id_valid   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_redir_pend <= w_redir_pend_nxt;
         r_id_addr    <= w_id_addr_nxt;
         r_id_inst    <= w_id_inst_nxt;
         r_id_valid   <= w_id_valid_nxt;
      end
   end

   // Targets are only consulted while their pending/DRAIN qualifier is set.
   always_ff @(posedge clk) begin
      r_redir_tgt <= w_redir_tgt_nxt;
      r_flush_pc  <= w_flush_pc_nxt;
   end

   assign rom_en   = (r_state == ST_REQ) || (r_state == ST_DRAIN);
   assign rom_addr = r_pc;
   assign id_addr  = r_id_addr;
   assign id_inst  = r_id_inst;
   assign id_valid = r_id_valid;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a variable-latency ROM responder.
module tb_inst_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_in = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] flush_pc = 32'h0;
   logic        branch_flag = 1'b0;
   logic [31:0] branch_addr = 32'h0;
   logic        rom_en;
   logic [31:0] rom_addr;
   logic        rom_ready = 1'b0;
   logic [31:0] rom_rdata = 32'h0;
   logic [31:0] id_addr;
   logic [31:0] id_inst;
   logic        id_valid;

   int checks = 0;
   int errors = 0;
   int lat = 1;
   int cnt = 0;
   logic en_prev = 1'b0;

   localparam logic [31:0] BASE = 32'hBFC0_0000;

   inst_fetch dut (
      .clk         (clk),
      .rst         (rst),
      .stall_in    (stall_in),
      .flush       (flush),
      .flush_pc    (flush_pc),
      .branch_flag (branch_flag),
      .branch_addr (branch_addr),
      .rom_en      (rom_en),
      .rom_addr    (rom_addr),
      .rom_ready   (rom_ready),
      .rom_rdata   (rom_rdata),
      .id_addr     (id_addr),
      .id_inst     (id_inst),
      .id_valid    (id_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'h5A5A_A5A5;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ROM answers once a request has been held for lat full cycles.
   task automatic tick();
      @(posedge clk);
      #1;
      if (rom_ready)    cnt = 0;
      else if (en_prev) cnt++;
      else              cnt = 0;
      en_prev   = rom_en;
      rom_ready = rom_en && (cnt >= lat);
      rom_rdata = rom_ready ? inst_of(rom_addr) : 32'h0;
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!id_valid && n < 20);
      chk("wait_valid", {31'b0, id_valid}, 32'h1);
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!rom_ready && n < 20) begin
         tick();
         n++;
      end
      chk("wait_ready", {31'b0, rom_ready}, 32'h1);
   endtask

   initial begin
      // reset state
      tick();
      tick();
      chk("rst_en",    {31'b0, rom_en}, 32'h0);
      chk("rst_addr",  rom_addr, BASE);
      chk("rst_idadr", id_addr, 32'h0);
      chk("rst_inst",  id_inst, 32'h0);
      chk("rst_vld",   {31'b0, id_valid}, 32'h0);
      rst = 1'b0;

      // 1: sequential fetch, latency 1
      tick();
      chk("t1_en",   {31'b0, rom_en}, 32'h1);
      chk("t1_addr", rom_addr, BASE);
      chk("t1_vld0", {31'b0, id_valid}, 32'h0);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("t1_bub_vld",  {31'b0, id_valid}, 32'h0);
         chk("t1_bub_addr", rom_addr, BASE + 32'(4 * k));
         tick();
         chk("t1_vld",    {31'b0, id_valid}, 32'h1);
         chk("t1_idaddr", id_addr, BASE + 32'(4 * k));
         chk("t1_inst",   id_inst, inst_of(BASE + 32'(4 * k)));
         chk("t1_next",   rom_addr, BASE + 32'(4 * k + 4));
      end

      // 2: branch at BFC00010 resolved in the cycle the delay slot arrives
      stall_in = 1'b1;
      tick();
      chk("t2_hold", id_addr, BASE + 32'h10);
      stall_in    = 1'b0;
      branch_flag = 1'b1;
      branch_addr = BASE + 32'h100;
      tick();
      branch_flag = 1'b0;
      chk("t2_ds",    id_addr, BASE + 32'h14);
      chk("t2_dsvld", {31'b0, id_valid}, 32'h1);
      chk("t2_pc",    rom_addr, BASE + 32'h100);
      wait_valid();
      chk("t2_tgt",   id_addr, BASE + 32'h100);

      // 3: latency 4, ID consumes the branch before the delay slot arrives
      lat = 4;
      wait_valid();
      chk("t3_br", id_addr, BASE + 32'h104);
      branch_flag = 1'b1;
      branch_addr = BASE + 32'h200;
      tick();
      branch_flag = 1'b0;
      chk("t3_bub",     {31'b0, id_valid}, 32'h0);
      chk("t3_bubinst", id_inst, 32'h0);
      chk("t3_bubaddr", id_addr, BASE + 32'h104);
      wait_valid();
      chk("t3_ds",  id_addr, BASE + 32'h108);
      chk("t3_pc",  rom_addr, BASE + 32'h200);
      wait_valid();
      chk("t3_tgt", id_addr, BASE + 32'h200);

      // 4: word arrives while ID stalls
      stall_in = 1'b1;
      wait_ready();
      chk("t4_frz", id_addr, BASE + 32'h200);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t4_en",   {31'b0, rom_en}, 32'h0);
         chk("t4_addr", id_addr, BASE + 32'h200);
         chk("t4_vld",  {31'b0, id_valid}, 32'h1);
      end
      stall_in = 1'b0;
      tick();
      chk("t4_out",  id_addr, BASE + 32'h204);
      chk("t4_inst", id_inst, inst_of(BASE + 32'h204));
      chk("t4_vld1", {31'b0, id_valid}, 32'h1);
      chk("t4_en1",  {31'b0, rom_en}, 32'h1);
      chk("t4_pc",   rom_addr, BASE + 32'h208);

      // 5: flush with a fetch outstanding, then a second flush while draining
      flush    = 1'b1;
      flush_pc = BASE + 32'h300;
      tick();
      chk("t5_bub",  {31'b0, id_valid}, 32'h0);
      chk("t5_en",   {31'b0, rom_en}, 32'h1);
      chk("t5_same", rom_addr, BASE + 32'h208);
      flush_pc = BASE + 32'h380;
      tick();
      flush = 1'b0;
      chk("t5_same2", rom_addr, BASE + 32'h208);
      wait_ready();
      tick();
      chk("t5_new",  rom_addr, BASE + 32'h380);
      chk("t5_vld0", {31'b0, id_valid}, 32'h0);
      wait_valid();
      chk("t5_id",   id_addr, BASE + 32'h380);
      chk("t5_inst", id_inst, inst_of(BASE + 32'h380));

      // 6: asynchronous reset mid-request
      tick();
      rst       = 1'b1;
      rom_ready = 1'b0;
      #1;
      chk("t6_en",    {31'b0, rom_en}, 32'h0);
      chk("t6_idadr", id_addr, 32'h0);
      chk("t6_inst",  id_inst, 32'h0);
      chk("t6_vld",   {31'b0, id_valid}, 32'h0);
      chk("t6_addr",  rom_addr, BASE);
      tick();
      rst       = 1'b0;
      lat       = 1;
      rom_ready = 1'b1;
      rom_rdata = 32'hDEAD_BEEF;
      tick();
      chk("t6_ign",   {31'b0, id_valid}, 32'h0);
      chk("t6_en1",   {31'b0, rom_en}, 32'h1);
      chk("t6_raddr", rom_addr, BASE);

      // pc wrap after a flush to the top of the address space
      flush    = 1'b1;
      flush_pc = 32'hFFFF_FFFC;
      tick();
      flush = 1'b0;
      chk("t7_drain", rom_addr, BASE);
      wait_ready();
      tick();
      chk("t7_pc", rom_addr, 32'hFFFF_FFFC);
      wait_valid();
      chk("t7_top", id_addr, 32'hFFFF_FFFC);
      chk("t7_wpc", rom_addr, 32'h0);
      wait_valid();
      chk("t7_wrap", id_addr, 32'h0);
      chk("t7_winst", id_inst, inst_of(32'h0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
